// File: rtl/game_pkg.sv
// Shared screen/winner codes, reset values and small helpers for the game-flow logic.
package game_pkg;

  typedef enum logic [1:0] {
    SCR_MENU      = 2'd0,
    SCR_COUNTDOWN = 2'd1,
    SCR_RACE      = 2'd2,
    SCR_RESULT    = 2'd3
  } screen_e;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_DRAW = 2'd3;

  localparam screen_e     RST_SCREEN    = SCR_MENU;
  localparam logic [1:0]  RST_COUNTDOWN = 2'd0;
  localparam logic        RST_RACE_EN   = 1'b0;
  localparam logic [15:0] RST_RACE_TIME = 16'd0;
  localparam logic [1:0]  RST_WINNER    = WIN_NONE;
  localparam logic        RST_VSYNC_Q   = 1'b1;
  localparam logic        RST_START_Q   = 1'b1;

  localparam logic [1:0]  CD_FIRST      = 2'd3;

  // Bit 0 marks P1, bit 1 marks P2, so both set gives WIN_DRAW.
  function automatic logic [1:0] pick_winner(input logic p1_wins, input logic p2_wins);
    return {p2_wins, p1_wins};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector; the delayed copy resets to RST_VAL so a level
// already high at reset release does not look like an edge.
module edge_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise
);

  logic r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_q <= RST_VAL;
    else       r_q <= i_d;
  end

  assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/race_ctrl.sv
// Game-flow controller: sequences MENU -> COUNTDOWN -> RACE -> RESULT from
// vsync frame ticks and player inputs; all outputs registered.
//
//   state         | meaning
//   SCR_MENU      | idle, waits for a start edge
//   SCR_COUNTDOWN | digits 3,2,1 held FRAMES_PER_STEP ticks each; throttle = false start
//   SCR_RACE      | cars enabled, race_time counts ticks until finish or timeout
//   SCR_RESULT    | winner/time frozen, held at least RESULT_FRAMES ticks
module race_ctrl
  import game_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 60,
  parameter int RACE_TIMEOUT    = 3600,
  parameter int RESULT_FRAMES   = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        start_in,
  input  logic        throttle_p1,
  input  logic        throttle_p2,
  input  logic        finish_p1,
  input  logic        finish_p2,
  output logic [1:0]  screen_sel,
  output logic [1:0]  countdown,
  output logic        race_en,
  output logic [15:0] race_time,
  output logic [1:0]  winner
);

  localparam logic [15:0] STEP_LAST   = 16'(FRAMES_PER_STEP - 1);
  localparam logic [15:0] TIMEOUT_VAL = 16'(RACE_TIMEOUT);
  localparam logic [15:0] RESULT_VAL  = 16'(RESULT_FRAMES);

  screen_e     r_state;
  logic [15:0] r_fcnt;
  logic [1:0]  r_countdown;
  logic        r_race_en;
  logic [15:0] r_race_time;
  logic [1:0]  r_winner;

  logic        w_tick;
  logic        w_start_rise;
  logic        w_false_start;
  logic        w_any_finish;
  logic [15:0] w_time_next;

  edge_detect #(.RST_VAL(RST_VSYNC_Q)) u_vsync_edge (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_d    (vsync_in),
    .o_rise (w_tick)
  );

  edge_detect #(.RST_VAL(RST_START_Q)) u_start_edge (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_d    (start_in),
    .o_rise (w_start_rise)
  );

  assign w_false_start = throttle_p1 | throttle_p2;
  assign w_any_finish  = finish_p1 | finish_p2;
  assign w_time_next   = w_tick ? sat_inc16(r_race_time) : r_race_time;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RST_SCREEN;
      r_fcnt      <= 16'd0;
      r_countdown <= RST_COUNTDOWN;
      r_race_en   <= RST_RACE_EN;
      r_race_time <= RST_RACE_TIME;
      r_winner    <= RST_WINNER;
    end else begin
      case (r_state)
        SCR_MENU: begin
          if (w_start_rise) begin
            r_state     <= SCR_COUNTDOWN;
            r_fcnt      <= 16'd0;
            r_countdown <= CD_FIRST;
            r_winner    <= WIN_NONE;
            r_race_time <= 16'd0;
          end
        end

        SCR_COUNTDOWN: begin
          // A throttle press beats a same-cycle tick; the offender loses.
          if (w_false_start) begin
            r_state     <= SCR_RESULT;
            r_fcnt      <= 16'd0;
            r_countdown <= 2'd0;
            r_winner    <= pick_winner(throttle_p2, throttle_p1);
          end else if (w_tick) begin
            if (r_fcnt == STEP_LAST) begin
              r_fcnt <= 16'd0;
              if (r_countdown == 2'd1) begin
                r_state     <= SCR_RACE;
                r_countdown <= 2'd0;
                r_race_en   <= 1'b1;
              end else begin
                r_countdown <= r_countdown - 2'd1;
              end
            end else begin
              r_fcnt <= r_fcnt + 16'd1;
            end
          end
        end

        SCR_RACE: begin
          r_race_time <= w_time_next;
          if (w_any_finish) begin
            r_state   <= SCR_RESULT;
            r_fcnt    <= 16'd0;
            r_race_en <= 1'b0;
            r_winner  <= pick_winner(finish_p1, finish_p2);
          end else if (w_tick && (w_time_next >= TIMEOUT_VAL)) begin
            r_state   <= SCR_RESULT;
            r_fcnt    <= 16'd0;
            r_race_en <= 1'b0;
            r_winner  <= WIN_NONE;
          end
        end

        SCR_RESULT: begin
          if (w_start_rise && (r_fcnt == RESULT_VAL)) begin
            r_state <= SCR_MENU;
            r_fcnt  <= 16'd0;
          end else if (w_tick && (r_fcnt < RESULT_VAL)) begin
            r_fcnt <= r_fcnt + 16'd1;
          end
        end

        default: begin
          r_state <= SCR_MENU;
          r_fcnt  <= 16'd0;
        end
      endcase
    end
  end

  assign screen_sel = r_state;
  assign countdown  = r_countdown;
  assign race_en    = r_race_en;
  assign race_time  = r_race_time;
  assign winner     = r_winner;

endmodule
